// File: rtl/column_encoder.sv
// Column encoder: captures a column flag vector and drains it as binary addresses, lowest index first.
// Latency: first addr_valid 1 cycle after load; done pulses 1 cycle after the final handshake.
// Backpressure: load_ready low while draining; addr/last held stable while addr_valid & !addr_ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   load_valid/load_ready    capture handshake for col_flags (bit i -> column address i)
//   addr/addr_valid/addr_ready/last  address stream; last marks the final address of a batch
//   busy                     batch in progress
//   done                     one-cycle pulse at batch completion (also for an all-zero vector)
//   remaining                popcount of outstanding flags, only when COL_ENC_COUNT_EN is defined
//
// Optional feature macro: COL_ENC_COUNT_EN (adds the remaining output).
// NUM_COLS must not exceed 2**ADDR_WIDTH so every flag bit has an address.
module column_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_COLS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [NUM_COLS-1:0]   col_flags,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  last,
    output logic                  busy,
`ifdef COL_ENC_COUNT_EN
    output logic [ADDR_WIDTH:0]   remaining,
`endif
    output logic                  done
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [NUM_COLS-1:0] ONE = {{(NUM_COLS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [NUM_COLS-1:0]   pending_q, pending_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] lowest_idx;
    logic [NUM_COLS-1:0]   pending_cleared;
    logic                  single_bit;

    // Priority encoder over the registered vector only; scanning downward
    // lets the lowest set bit win.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // x & (x-1) drops the lowest set bit: it is both the post-handshake
    // vector and, when zero, the proof that only one bit was set.
    assign pending_cleared = pending_q & (pending_q - ONE);
    assign single_bit      = (pending_q != '0) && (pending_cleared == '0);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        load_ready = 1'b0;
        addr_valid = 1'b0;
        busy       = 1'b0;
        addr       = '0;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    pending_d = col_flags;
                    if (col_flags != '0) begin
                        state_d = DRAIN;
                    end else begin
                        // Empty batch completes immediately with no address.
                        done_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                addr       = lowest_idx;
                last       = single_bit;
                if (addr_ready) begin
                    pending_d = pending_cleared;
                    if (single_bit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;

`ifdef COL_ENC_COUNT_EN
    // pending is all-zero whenever the FSM is idle, so the count reads 0 there.
    always_comb begin
        remaining = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            remaining = remaining + {{ADDR_WIDTH{1'b0}}, pending_q[i]};
        end
    end
`endif

endmodule

// File: tb/tb_column_encoder.sv
module tb_column_encoder;

    localparam int AW = 4;
    localparam int NC = 16;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [NC-1:0] col_flags;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;
    logic          last;
    logic          busy;
    logic          done;
`ifdef COL_ENC_COUNT_EN
    logic [AW:0]   remaining;
`endif

    column_encoder #(.ADDR_WIDTH(AW), .NUM_COLS(NC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .col_flags  (col_flags),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .last       (last),
        .busy       (busy),
`ifdef COL_ENC_COUNT_EN
        .remaining  (remaining),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int a, input logic l);
        exp_t e;
        e.addr = AW'(a);
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted address is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (addr_valid && addr_ready) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_addr: got addr=%0d last=%0b with empty scoreboard at %0t",
                             addr, last, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (addr !== e.addr || last !== e.last) begin
                        errors++;
                        $display("FAIL addr_stream: got addr=%0d last=%0b expected addr=%0d last=%0b at %0t",
                                 addr, last, e.addr, e.last, $time);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (busy || !load_ready || addr_valid) begin
                    errors++;
                    $display("FAIL done_cycle: busy=%0b load_ready=%0b addr_valid=%0b expected 0/1/0 at %0t",
                             busy, load_ready, addr_valid, $time);
                end
            end
        end
    end

    // Called one step after a posedge; capture happens at the next posedge.
    task automatic drive_load(input logic [NC-1:0] flags);
        load_valid = 1'b1;
        col_flags  = flags;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt != exp_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_count", done_cnt, exp_done);
        check("scoreboard_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int done_before;

        // Reset with a pending load that must not be captured.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        col_flags  = 16'hFFFF;
        addr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load_ready", load_ready, 1);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        check("rst_last", last, 0);
        load_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_idle", addr_valid, 0);
        @(posedge clk); #1;

        // 0x8421 with addr_ready held high: 0,5,10,15 back to back.
        addr_ready = 1'b1;
        push(0, 1'b0); push(5, 1'b0); push(10, 1'b0); push(15, 1'b1);
        exp_done++;
        drive_load(16'h8421);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (addr_valid) n++;
            else break;
        end
        check("k_handshake_cycles", n, 4);
        check("done_after_last", done, 1);
        check("busy_falls_with_done", busy, 0);
        wait_done();

        // 0x0003 stalled for 4 cycles, with an ignored load pulse of 0xFFFF.
        addr_ready = 1'b0;
        push(0, 1'b0); push(1, 1'b1);
        exp_done++;
        drive_load(16'h0003);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", addr_valid, 1);
            check("stall_addr", addr, 0);
            check("stall_last", last, 0);
            check("stall_load_ready", load_ready, 0);
            @(posedge clk); #1;
            if (i == 1) begin
                load_valid = 1'b1;
                col_flags  = 16'hFFFF;
            end else begin
                load_valid = 1'b0;
            end
        end
        addr_ready = 1'b1;
        @(negedge clk);
        check("drain_load_ready", load_ready, 0);
        wait_done();

        // Empty vector, then back-to-back load of 0x0001 in the done cycle.
        exp_done++;
        load_valid = 1'b1;
        col_flags  = 16'h0000;
        @(posedge clk); #1;
        col_flags = 16'h0001;
        push(0, 1'b1);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_no_valid", addr_valid, 0);
        check("zero_load_ready", load_ready, 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        exp_done++;
        @(negedge clk);
        check("b2b_done_single", done, 0);
        check("b2b_valid", addr_valid, 1);
        check("b2b_last", last, 1);
        wait_done();

        // 0xFFFF, three accepted addresses, then asynchronous reset mid-cycle.
        push(0, 1'b0); push(1, 1'b0); push(2, 1'b0);
        done_before = done_cnt;
        drive_load(16'hFFFF);
`ifdef COL_ENC_COUNT_EN
        check("remaining_16", remaining, 16);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
`ifdef COL_ENC_COUNT_EN
            check("remaining_dec", remaining, 15 - i);
`endif
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_addr_valid", addr_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_load_ready", load_ready, 1);
        check("arst_addr", addr, 0);
        check("arst_last", last, 0);
        check("arst_pending", dut.pending_q, 0);
`ifdef COL_ENC_COUNT_EN
        check("remaining_0", remaining, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
            check("arst_no_addr", addr_valid, 0);
        end
        check("arst_done_count", done_cnt, done_before);
        check("arst_scoreboard", exp_q.size(), 0);
        @(posedge clk); #1;

        // Round trip through a one-hot decoder output.
        for (int a = 0; a < NC; a++) begin
            logic [NC-1:0] onehot;
            onehot = '0;
            onehot[a] = 1'b1;
            push(a, 1'b1);
            exp_done++;
            drive_load(onehot);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/column_encoder.md
Name: column_encoder

Overview:
- Inverse of the SRAM column decoder: accepts a NUM_COLS-wide column flag vector (e.g. per-column write-done, mismatch or refresh-pending flags) and turns it back into binary column addresses.
- Captures one vector per batch and emits one address per accepted handshake, lowest index first.
- Sits between the column-side flag logic and the controller that re-drives the column decoder's addr input.

Parameters:
- ADDR_WIDTH, 4, column address width.
- NUM_COLS, 16, flag vector width. Must satisfy NUM_COLS <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  col_flags is valid for capture
- load_ready  output  1  encoder can accept a new vector
- col_flags  input  NUM_COLS  column flag vector; bit i maps to column address i
- addr  output  ADDR_WIDTH  encoded column address
- addr_valid  output  1  addr is valid
- addr_ready  input  1  consumer accepts addr
- last  output  1  current addr is the final one of the batch
- busy  output  1  batch in progress
- done  output  1  one-cycle pulse at batch completion

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE, pending = 0, done = 0.
  - Hence load_ready = 1, addr_valid = 0, addr = 0, last = 0, busy = 0.
- Registers: 2-state FSM (IDLE, DRAIN), pending[NUM_COLS-1:0], done flop.
- IDLE:
  - load_ready = 1, busy = 0, addr_valid = 0.
  - On load_valid & load_ready, pending <= col_flags.
  - If col_flags != 0: go to DRAIN next cycle.
  - If col_flags == 0: stay in IDLE and pulse done high for the next cycle only. No address is emitted.
- DRAIN:
  - load_ready = 0, busy = 1, addr_valid = 1.
  - load_valid is ignored.
  - addr = index of the lowest set bit of pending. This is combinational from the pending register only; it does not depend on any input port.
  - last = 1 iff pending has exactly one bit set.
  - On addr_valid & addr_ready, clear that bit in pending.
    - If last was 1: go to IDLE, and done = 1 in the following cycle.
    - Otherwise stay in DRAIN.
  - Throughput: one address per cycle while addr_ready is held high. addr/last are stable while addr_valid & !addr_ready.
- Latency:
  - Load to first addr_valid: 1 cycle.
  - Final handshake to done: 1 cycle. load_ready is also high in that same cycle, so a new load can happen in the done cycle.
  - Batch with k set bits and addr_ready held high: exactly k handshake cycles.
- Outputs outside DRAIN: addr = 0 and last = 0.
- Flag bits at or above NUM_COLS do not exist; no out-of-range address can be produced.
- Reset asserted mid-batch: pending is cleared immediately and the FSM returns to IDLE. done is not pulsed and no further addresses are emitted.
- col_flags changing while in DRAIN has no effect.

Optional Feature:
- Macro: COL_ENC_COUNT_EN.
- When defined:
  - Extra output port remaining, ADDR_WIDTH+1 bits = popcount(pending), combinational from the register.
  - remaining = 0 in IDLE; it decrements by 1 per accepted address.
  - After a capture it equals the number of set bits in col_flags; it reads 16 for all-ones with the defaults.
- When undefined: the port and popcount logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n low for 3 cycles, with load_valid = 1 and col_flags = 16'hFFFF -> load_ready = 1, addr_valid = 0, busy = 0, done = 0. No capture occurs.
- Load 16'h8421 with addr_ready held high -> addr sequence 0, 5, 10, 15 on consecutive cycles, with last = 1 only on 15. done pulses once on the next cycle, and busy falls with it.
- Load 16'h0003 with addr_ready = 0 for 4 cycles, then 1 -> addr held at 0 with addr_valid = 1 while stalled, then 0 then 1. load_ready stays 0 throughout DRAIN, including a load_valid pulse carrying 16'hFFFF, which must be ignored.
- Load 16'h0000 -> no addr_valid, done = 1 for exactly one cycle, state stays IDLE. A back-to-back load of 16'h0001 in the done cycle yields addr 0 with last = 1.
- Load 16'hFFFF, accept 3 addresses, then assert rst_n low asynchronously mid-cycle -> outputs go to reset values immediately, pending = 0, no done pulse. With COL_ENC_COUNT_EN defined, remaining reads 16, 15, 14, 13 before reset and 0 after.
- Round trip: for each a in 0..15, drive the one-hot decoder output (1 << a) into col_flags -> exactly one address equal to a, with last = 1.
